// File: rtl/skewed_sync_multi.sv
// skewed_sync_multi: multi-channel skewed synchronizer aligning unary bitstreams to a reference channel
// Each non-reference channel stores/releases 1s in a saturating counter to force SCC of +1 (mode=0) or -1 (mode=1).
module skewed_sync_multi #(
  parameter int CH   = 3,
  parameter int DEP  = 2,
  parameter int REF  = 0,
  parameter int OREG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                flush,
  input  logic [CH-1:0]       in,
  output logic [CH-1:0]       out,
  output logic [CH*DEP-1:0]   cnt_o,
  output logic                pending
);
  logic [CH-1:0] o;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    if (i == REF) begin : g_ref
      assign o[i] = in[i];
      assign cnt_o[i*DEP +: DEP] = '0;
    end else begin : g_skew
      logic [DEP-1:0] cnt;
      logic full, empty, up, dn;
      assign full  = &cnt;
      assign empty = ~|cnt;
      // store when this channel leads the wanted pairing; flush releases on any 0 slot
      assign up = en & ~flush & in[i] & (in[REF] == mode);
      assign dn = en & ~in[i] & (flush | (in[REF] != mode));
      assign o[i] = up ? full : dn ? ~empty : in[i];
      always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (up && !full) cnt <= cnt + DEP'(1);
        else if (dn && !empty) cnt <= cnt - DEP'(1);
      end
      assign cnt_o[i*DEP +: DEP] = cnt;
    end
  end
  assign pending = |cnt_o;
  if (OREG != 0) begin : g_oreg
    logic [CH-1:0] q;
    always_ff @(posedge clk) q <= rst_n ? o : '0;
    assign out = q;
  end else begin : g_comb
    assign out = rst_n ? o : '0;
  end
endmodule
